// File: rtl/difftest_stream_packer.sv
// difftest_stream_packer
//   Captures one wide difftest frame per in_valid cycle into a DEPTH-entry
//   frame FIFO and serialises each stored frame into OUT_W-bit beats on a
//   valid/ready/last stream toward the DMA send engine. Frames that arrive
//   while the FIFO is full are discarded, counted (saturating) and flagged
//   with a sticky overflow bit.
//
//   Optional build macro DIFFTEST_FRAME_SEQ_EN: every frame is preceded by a
//   header beat holding a 32-bit frame sequence number in [31:0] and a
//   snapshot of drop_cnt in [31+CNT_W:32]; all other header bits are zero.
//
// Ports
//   clock       : single clock
//   reset       : asynchronous active-low reset
//   in_valid    : frame strobe, one frame per high cycle
//   in_data     : frame payload (FRAME_W bits)
//   in_ready    : FIFO not full (advisory, source is never stalled)
//   out_data    : current beat (OUT_W bits), zero while out_valid is low
//   out_valid   : beat valid
//   out_ready   : sink accepts beat
//   out_last    : final beat of the frame
//   drop_cnt    : number of dropped frames, saturating
//   overflow    : sticky, set on the first drop
//   fifo_level  : frames stored, including the one being sent
module difftest_stream_packer #(
  parameter int FRAME_W = 3872,
  parameter int OUT_W   = 512,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [FRAME_W-1:0]       in_data,
  output logic                     in_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int BEATS  = (FRAME_W + OUT_W - 1) / OUT_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [PTR_W:0]    FULL      = (PTR_W + 1)'(DEPTH);

`ifdef DIFFTEST_FRAME_SEQ_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_SEND} state_e;
  localparam state_e S_FIRST = S_HDR;
`else
  typedef enum logic [1:0] {S_IDLE, S_SEND} state_e;
  localparam state_e S_FIRST = S_SEND;
`endif

  state_e                 state_q, state_d;
  logic [BEAT_W-1:0]      beat_q, beat_d;
  logic [PTR_W:0]         cnt_q, cnt_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       drop_q, drop_d;
  logic                   ovf_q, ovf_d;
`ifdef DIFFTEST_FRAME_SEQ_EN
  logic [31:0]            seq_q, seq_d;
  logic [CNT_W-1:0]       snap_q, snap_d;
  logic [OUT_W-1:0]       hdr;
`endif

  logic [FRAME_W-1:0]     mem_q [DEPTH];
  logic [BEATS*OUT_W-1:0] padded;
  logic                   push, drop, pop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Full is judged on the registered count only, so a push that coincides
  // with the final-beat pop of a full FIFO is still dropped.
  assign push = in_valid && (cnt_q != FULL);
  assign drop = in_valid && (cnt_q == FULL);
  assign pop  = (state_q == S_SEND) && out_ready && (beat_q == LAST_BEAT);

  // Head frame widened to a whole number of beats; bits above FRAME_W are zero.
  always_comb begin
    padded = '0;
    padded[FRAME_W-1:0] = mem_q[rd_ptr_q];
  end

`ifdef DIFFTEST_FRAME_SEQ_EN
  always_comb begin
    hdr = '0;
    hdr[31:0] = seq_q;
    hdr[32 +: CNT_W] = snap_q;
  end
`endif

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
`ifdef DIFFTEST_FRAME_SEQ_EN
    seq_d     = seq_q;
    snap_d    = snap_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          state_d = S_FIRST;
          beat_d  = '0;
`ifdef DIFFTEST_FRAME_SEQ_EN
          snap_d  = drop_q;
`endif
        end
      end
`ifdef DIFFTEST_FRAME_SEQ_EN
      S_HDR: begin
        out_valid = 1'b1;
        out_data  = hdr;
        if (out_ready) begin
          state_d = S_SEND;
          beat_d  = '0;
          seq_d   = seq_q + 32'd1;
        end
      end
`endif
      S_SEND: begin
        out_valid = 1'b1;
        out_data  = padded[int'(beat_q) * OUT_W +: OUT_W];
        out_last  = (beat_q == LAST_BEAT);
        if (out_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            // Chain straight into the next stored frame without a bubble.
            if (cnt_q > (PTR_W + 1)'(1)) begin
              state_d = S_FIRST;
`ifdef DIFFTEST_FRAME_SEQ_EN
              snap_d  = drop_q;
`endif
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    drop_d   = drop ? sat_inc(drop_q) : drop_q;
    ovf_d    = ovf_q | drop;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
`ifdef DIFFTEST_FRAME_SEQ_EN
      seq_q    <= '0;
      snap_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
`ifdef DIFFTEST_FRAME_SEQ_EN
      seq_q    <= seq_d;
      snap_q   <= snap_d;
`endif
    end
  end

  // Frame storage carries data only and is deliberately left unreset.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ready   = (cnt_q != FULL);
  assign fifo_level = cnt_q;
  assign drop_cnt   = drop_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/difftest_stream_packer.md
Name: difftest_stream_packer

Overview:
- Parametrised successor to the fixed-width difftest gateway wrapper.
- Captures one wide difftest frame per `in_valid` pulse into a DEPTH-entry frame FIFO.
- Serialises each stored frame into OUT_W-bit beats on a stream interface (valid/ready/last) toward the DMA send engine.
- Counts and flags frames dropped while the FIFO is full.

Parameters:
- FRAME_W, 3872: total width of one concatenated difftest frame; must be ≥ 1.
- OUT_W, 512: stream beat width; must be a multiple of 32 and ≥ 64.
- DEPTH, 4: frame FIFO entries; must be a power of two and ≥ 2.
- CNT_W, 16: width of the drop counter.

Ports:
- clock, input, 1: single clock.
- reset, input, 1: asynchronous active-low reset.
- in_valid, input, 1: frame strobe; one frame per cycle high.
- in_data, input, FRAME_W: frame payload, sampled when in_valid = 1.
- in_ready, output, 1: high when FIFO count != DEPTH. Advisory only; the source is never stalled.
- out_data, output, OUT_W: current beat.
- out_valid, output, 1: beat valid.
- out_ready, input, 1: sink accepts beat.
- out_last, output, 1: final beat of the frame.
- drop_cnt, output, CNT_W: frames dropped; saturating.
- overflow, output, 1: sticky; set on first drop.
- fifo_level, output, $clog2(DEPTH)+1: frames stored, including the frame being sent.

Behaviour:
- Clock and reset:
  - One clock.
  - reset is asynchronous, active-low. Assertion clears state immediately; deassertion is synchronous to clock.
- Reset values:
  - out_valid = 0, out_last = 0, out_data = 0.
  - drop_cnt = 0, overflow = 0, fifo_level = 0, in_ready = 1.
  - FSM = IDLE; beat index = 0.
- Derived value: BEATS = ceil(FRAME_W/OUT_W). Default is 8.
- Beat layout:
  - Beat k carries frame bits [k*OUT_W +: OUT_W].
  - The last beat is zero-padded above FRAME_W.
- Push:
  - When in_valid = 1 and the registered count < DEPTH, the frame is written at the rising edge.
  - When count == DEPTH, the frame is discarded, drop_cnt increments (saturates at all-ones), and overflow is set.
  - A push in the same cycle as the final-beat pop of a full FIFO is still dropped. Full is evaluated on the registered count.
- Pop: the FIFO entry is freed on the handshake out_valid && out_ready && out_last.
- Simultaneous accepted push and final-beat pop: count is unchanged.
- FSM:
  - IDLE: if count > 0, load head frame, beat index = 0, go to SEND. out_valid rises 1 cycle after FSM sees a non-empty FIFO. A frame pushed at edge t has its first beat valid at t+1 (minimum latency 1 cycle).
  - SEND:
    - out_valid = 1.
    - On handshake, increment beat index.
    - out_last = 1 when index == BEATS-1.
    - On the last handshake: if count − 1 > 0, load the next frame and stay in SEND with no bubble cycle; else go to IDLE.
- Stream rules:
  - While out_valid && !out_ready, out_data and out_last hold stable.
  - out_valid never drops without a handshake, except on reset.
- Reset mid-frame: the partial frame is abandoned and no out_last is emitted for it. The sink must discard the partial frame.
- BEATS == 1 is legal: out_last = 1 on every beat.
- drop_cnt and overflow clear only on reset.

Optional Feature:
- Macro: DIFFTEST_FRAME_SEQ_EN.
- When defined:
  - Each frame is preceded by one header beat, so BEATS+1 beats are sent per frame.
  - Header layout: [31:0] = 32-bit frame sequence number (starts at 0 after reset, +1 per accepted frame, wraps at 2^32); [31+CNT_W:32] = drop_cnt snapshot at header launch; remaining bits = 0.
  - The FSM gains state HDR between IDLE/SEND-completion and the payload beats.
  - out_last is never set on the header beat.
  - Dropped frames do not consume sequence numbers.
- When undefined: no header beat, no sequence counter, BEATS beats per frame.

Test Plan:
- Single frame, out_ready = 1 constantly, in_data = incrementing 32-bit words → 8 beats on consecutive cycles starting 1 cycle after push; beat 7 has bits [511:288] = 0 and out_last = 1; fifo_level returns to 0.
- Back-pressure: out_ready toggles 1,0,0,1 repeating → out_data and out_last stable during stalls; exactly 8 handshakes; no duplicated or skipped beats.
- Overflow: out_ready = 0, push 6 frames → fifo_level = 4, drop_cnt = 2, overflow = 1, in_ready = 0. Then release out_ready → the 4 stored frames emerge in order with no idle cycle between frames.
- Full-FIFO same-cycle push on final-beat pop → push dropped, drop_cnt increments, level goes to 3.
- Reset asserted at beat 3 of a frame → all outputs at reset values immediately (asynchronously), before the next clock edge; next pushed frame starts at beat 0.
- With DIFFTEST_FRAME_SEQ_EN: push 3 frames with 1 dropped in between (FIFO full) → headers carry seq 0, 1, 2 and drop_cnt snapshot 0, 0, 1; 9 beats per frame.
